// File: rtl/audio_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : audio_event_scheduler
// Brief    : Shares one tone generator between countdown-tick, goal and
//            match-finish events. Fixed-priority arbitration, pending latches,
//            finish preemption and note/gap melody sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module audio_event_scheduler #(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_tick,
  input  logic       req_goal,
  input  logic       req_finish,
  input  logic       mute,
  output logic [3:0] note_code,
  output logic       note_valid,
  output logic       busy,
  output logic [1:0] active,
  output logic       tick_drop
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_TICK   = 2'd1;
  localparam logic [1:0] EV_GOAL   = 2'd2;
  localparam logic [1:0] EV_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Melody ROM: note code for a given event and note index (0 = silence).
  function automatic logic [3:0] rom_note(input logic [1:0] ev, input logic [1:0] idx);
    logic [3:0] n;
    n = 4'd0;
    case ({ev, idx})
      {EV_TICK,   2'd0}: n = 4'd1;
      {EV_GOAL,   2'd0}: n = 4'd3;
      {EV_GOAL,   2'd1}: n = 4'd5;
      {EV_GOAL,   2'd2}: n = 4'd8;
      {EV_FINISH, 2'd0}: n = 4'd8;
      {EV_FINISH, 2'd1}: n = 4'd6;
      {EV_FINISH, 2'd2}: n = 4'd4;
      {EV_FINISH, 2'd3}: n = 4'd1;
      default:           n = 4'd0;
    endcase
    return n;
  endfunction

  // Index of the final note of each melody.
  function automatic logic [1:0] last_idx(input logic [1:0] ev);
    logic [1:0] l;
    case (ev)
      EV_GOAL:   l = 2'd2;
      EV_FINISH: l = 2'd3;
      default:   l = 2'd0;
    endcase
    return l;
  endfunction

  state_t           r_state, w_state_n;
  logic [1:0]       r_idx, w_idx_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [1:0]       r_active, w_active_n;
  logic             r_p_tick, r_p_goal, r_p_finish;
  logic             w_p_tick_n, w_p_goal_n, w_p_finish_n;
  logic             r_tick_drop, w_tick_drop_n;

  logic             w_cand_tick, w_cand_goal, w_cand_finish, w_any;
  logic [1:0]       w_pick;
  logic             w_preempt;
  logic             w_start;
  logic [1:0]       w_start_ev;
  logic             w_g_tick, w_g_goal, w_g_finish;
  logic [3:0]       w_note;

  // Candidate events: fresh requests plus latched pending bits, finish > goal > tick.
  always_comb begin
    w_cand_tick   = req_tick   | r_p_tick;
    w_cand_goal   = req_goal   | r_p_goal;
    w_cand_finish = req_finish | r_p_finish;
    w_any         = w_cand_tick | w_cand_goal | w_cand_finish;
    w_pick        = EV_NONE;
    if (w_cand_finish)    w_pick = EV_FINISH;
    else if (w_cand_goal) w_pick = EV_GOAL;
    else if (w_cand_tick) w_pick = EV_TICK;
    // Only finish may interrupt, and never another finish.
    w_preempt     = w_cand_finish && (r_active != EV_FINISH);
  end

  // Next-state, sequencing and pending-bit logic.
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_cnt_n    = r_cnt;
    w_active_n = r_active;
    w_start    = 1'b0;
    w_start_ev = EV_NONE;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_start    = 1'b1;
          w_start_ev = w_pick;
        end
      end
      S_PLAY: begin
        if (w_preempt) begin
          w_start    = 1'b1;
          w_start_ev = EV_FINISH;
        end else if (r_cnt == NOTE_LAST) begin
          w_state_n = S_GAP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (w_preempt) begin
          w_start    = 1'b1;
          w_start_ev = EV_FINISH;
        end else if (r_cnt == GAP_LAST) begin
          if (r_idx != last_idx(r_active)) begin
            w_state_n = S_PLAY;
            w_idx_n   = r_idx + 2'd1;
            w_cnt_n   = '0;
          end else if (w_any) begin
            // Back-to-back melodies: no idle cycle between them.
            w_start    = 1'b1;
            w_start_ev = w_pick;
          end else begin
            w_state_n  = S_IDLE;
            w_idx_n    = 2'd0;
            w_cnt_n    = '0;
            w_active_n = EV_NONE;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_idx_n    = 2'd0;
        w_cnt_n    = '0;
        w_active_n = EV_NONE;
      end
    endcase

    if (w_start) begin
      w_state_n  = S_PLAY;
      w_idx_n    = 2'd0;
      w_cnt_n    = '0;
      w_active_n = w_start_ev;
    end

    w_g_tick   = w_start && (w_start_ev == EV_TICK);
    w_g_goal   = w_start && (w_start_ev == EV_GOAL);
    w_g_finish = w_start && (w_start_ev == EV_FINISH);

    // A request that is not granted always lands in its pending bit, even
    // when the same edge would otherwise clear it. Finish grants flush the
    // lower-priority queue.
    if (req_tick && !w_g_tick)          w_p_tick_n = 1'b1;
    else if (w_g_tick || w_g_finish)    w_p_tick_n = 1'b0;
    else                                w_p_tick_n = r_p_tick;

    if (req_goal && !w_g_goal)          w_p_goal_n = 1'b1;
    else if (w_g_goal || w_g_finish)    w_p_goal_n = 1'b0;
    else                                w_p_goal_n = r_p_goal;

    if (req_finish && !w_g_finish)      w_p_finish_n = 1'b1;
    else if (w_g_finish)                w_p_finish_n = 1'b0;
    else                                w_p_finish_n = r_p_finish;

    // Tick merged into an already-waiting tick.
    w_tick_drop_n = req_tick && r_p_tick && !w_g_tick;
  end

  // State, sequencing and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_active    <= EV_NONE;
      r_p_tick    <= 1'b0;
      r_p_goal    <= 1'b0;
      r_p_finish  <= 1'b0;
      r_tick_drop <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_cnt       <= w_cnt_n;
      r_active    <= w_active_n;
      r_p_tick    <= w_p_tick_n;
      r_p_goal    <= w_p_goal_n;
      r_p_finish  <= w_p_finish_n;
      r_tick_drop <= w_tick_drop_n;
    end
  end

  // Note output: ROM lookup while playing, silenced by mute or gaps.
  always_comb begin
    w_note = 4'd0;
    if ((r_state == S_PLAY) && !mute) w_note = rom_note(r_active, r_idx);
  end

  assign note_code  = w_note;
  assign note_valid = |w_note;
  assign busy       = (r_state != S_IDLE);
  assign active     = r_active;
  assign tick_drop  = r_tick_drop;

endmodule
`default_nettype wire

// File: tb/tb_audio_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_event_scheduler
// Brief    : Directed self-checking bench for audio_event_scheduler with
//            NOTE_CYCLES=4, GAP_CYCLES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_event_scheduler;

  logic       clk;
  logic       rst;
  logic       req_tick, req_goal, req_finish, mute;
  logic [3:0] note_code;
  logic       note_valid, busy, tick_drop;
  logic [1:0] active;

  int checks = 0;
  int errors = 0;

  audio_event_scheduler #(
    .NOTE_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tick  (req_tick),
    .req_goal  (req_goal),
    .req_finish(req_finish),
    .mute      (mute),
    .note_code (note_code),
    .note_valid(note_valid),
    .busy      (busy),
    .active    (active),
    .tick_drop (tick_drop)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
      end
  endtask

  // Drive one cycle's inputs, check that cycle's outputs, then advance to
  // 1 ns after the next rising edge.
  task automatic run_cycle(input int c, input logic rt, input logic rg, input logic rf,
                           input logic m, input logic r, input logic [3:0] en,
                           input logic eb, input logic [1:0] ea, input logic etd);
    req_tick = rt; req_goal = rg; req_finish = rf; mute = m; rst = r;
    #2;
    chk("note_code",  c, note_code, en);
    chk("note_valid", c, {3'b0, note_valid}, {3'b0, (en != 4'd0)});
    chk("busy",       c, {3'b0, busy}, {3'b0, eb});
    chk("active",     c, {2'b0, active}, {2'b0, ea});
    chk("tick_drop",  c, {3'b0, tick_drop}, {3'b0, etd});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_tick = 0; req_goal = 0; req_finish = 0; mute = 0; rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Goal melody timing with tick following: goal notes at 1-4/7-10/13-16,
  // tick note at 19-22, busy through cycle 24.
  function automatic logic [3:0] goal_then_tick_note(input int c);
    if (c >= 1  && c <= 4)  return 4'd3;
    if (c >= 7  && c <= 10) return 4'd5;
    if (c >= 13 && c <= 16) return 4'd8;
    if (c >= 19 && c <= 22) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [1:0] goal_then_tick_active(input int c);
    if (c >= 1  && c <= 18) return 2'd2;
    if (c >= 19 && c <= 24) return 2'd1;
    return 2'd0;
  endfunction

  initial begin
    req_tick = 0; req_goal = 0; req_finish = 0; mute = 0; rst = 1;
    #1;

    // Reset state.
    do_reset();
    for (int c = 0; c < 2; c++) run_cycle(c, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0);

    // Single tick: note 1 in cycles 1-4, gap 5-6, idle from 7.
    for (int c = 0; c <= 9; c++)
      run_cycle(c, (c == 0), 0, 0, 0, 0,
                (c >= 1 && c <= 4) ? 4'd1 : 4'd0,
                (c >= 1 && c <= 6),
                (c >= 1 && c <= 6) ? 2'd1 : 2'd0, 0);

    // Simultaneous tick + goal: goal first, tick directly after.
    do_reset();
    for (int c = 0; c <= 27; c++)
      run_cycle(c, (c == 0), (c == 0), 0, 0, 0,
                goal_then_tick_note(c), (c >= 1 && c <= 24),
                goal_then_tick_active(c), 0);

    // Finish preempts goal during its first gap; goal never resumes.
    do_reset();
    for (int c = 0; c <= 33; c++) begin
      logic [3:0] en;
      logic [1:0] ea;
      en = 4'd0;
      if (c >= 1  && c <= 4)  en = 4'd3;
      if (c >= 7  && c <= 10) en = 4'd8;
      if (c >= 13 && c <= 16) en = 4'd6;
      if (c >= 19 && c <= 22) en = 4'd4;
      if (c >= 25 && c <= 28) en = 4'd1;
      ea = 2'd0;
      if (c >= 1 && c <= 6)  ea = 2'd2;
      if (c >= 7 && c <= 30) ea = 2'd3;
      run_cycle(c, 0, (c == 0), (c == 6), 0, 0, en, (c >= 1 && c <= 30), ea, 0);
    end

    // Coalescing: second tick while one is pending pulses tick_drop in cycle 6,
    // and exactly one tick melody follows goal.
    do_reset();
    for (int c = 0; c <= 30; c++)
      run_cycle(c, (c == 2 || c == 5), (c == 0), 0, 0, 0,
                goal_then_tick_note(c), (c >= 1 && c <= 24),
                goal_then_tick_active(c), (c == 6));

    // Mute over goal melody keeps timing; reset at cycle 9 clears everything,
    // including the pending tick.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      logic [3:0] en;
      logic       eb;
      logic [1:0] ea;
      en = (c == 9) ? 4'd5 : 4'd0;
      eb = (c >= 1 && c <= 9);
      ea = eb ? 2'd2 : 2'd0;
      run_cycle(c, (c == 2), (c == 0), 0, (c >= 1 && c <= 8), (c == 9), en, eb, ea, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_event_scheduler.md
Name: audio_event_scheduler

Overview:
- Shares the single tone generator / PMOD audio path between three game event sources: countdown tick, goal, and match finish.
- Arbitrates simultaneous requests by fixed priority and latches requests that arrive while busy.
- Sequences each event's short melody note by note, with a silent gap after every note.
- Sits between the game FSM (event pulses) and the tone generator (note_code input).

Parameters:
- NOTE_CYCLES, 12500000: clk cycles each note sounds (0.125 s at 100 MHz); must be >= 1.
- GAP_CYCLES, 2500000: clk cycles of silence after each note; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- req_tick  input  1  single-cycle pulse, countdown second elapsed
- req_goal  input  1  single-cycle pulse, goal scored
- req_finish  input  1  single-cycle pulse, match over
- mute  input  1  level; silences outputs without stopping sequencing
- note_code  output  4  note index to tone generator; 0 = silence
- note_valid  output  1  high while a note sounds, i.e. note_code != 0
- busy  output  1  high from grant through end of the last gap of the current melody
- active  output  2  current event: 0 none, 1 tick, 2 goal, 3 finish
- tick_drop  output  1  one-cycle pulse when a tick request coalesces into an already pending tick

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state IDLE; pending bits, note index and duration counter cleared.
  - Outputs: note_code 0, note_valid 0, busy 0, active 0, tick_drop 0.
  - Reset mid-melody silences outputs from the cycle after the sampling edge.
- Melody ROM (note codes, in order):
  - tick: 1
  - goal: 3, 5, 8
  - finish: 8, 6, 4, 1
- Pending bits (p_tick, p_goal, p_finish):
  - Set by the matching request at any edge where that request is not granted.
  - A request arriving on the same edge its pending bit clears leaves the bit set.
- Priority: finish > goal > tick.
- States: IDLE, PLAY, GAP.
  - IDLE: on an edge with any request or pending bit, grant the highest priority one.
    - Go to PLAY with note index 0 and counter 0; clear the granted pending bit.
    - Non-granted simultaneous requests become pending.
  - PLAY: note_code = ROM[active][index]. The counter counts NOTE_CYCLES cycles, then the FSM goes to GAP.
  - GAP: note_code 0 for GAP_CYCLES cycles. Then:
    - if more notes remain, PLAY with index+1;
    - otherwise, if anything is pending, grant it directly on the same edge (PLAY, zero idle cycles);
    - otherwise go to IDLE.
- Latency: a request sampled at edge E in IDLE produces its first note in the cycle after E.
  - A tick request therefore keeps busy high for NOTE_CYCLES+GAP_CYCLES cycles.
- Preemption:
  - A finish request (or p_finish) while a tick or goal melody is active aborts it at the next edge and starts finish note 0.
  - The aborted melody is dropped, not resumed.
  - Granting finish clears p_goal and p_tick.
  - Finish never preempts finish; a repeat finish request during finish sets p_finish.
- Coalescing: a tick request while p_tick is already 1 leaves p_tick at 1 and pulses tick_drop the next cycle.
  - Repeated goal or finish requests also coalesce, but do not pulse tick_drop.
- Mute: forces note_code 0 and note_valid 0.
  - State, counters, busy and active continue unchanged.
- Counter width: $clog2(max(NOTE_CYCLES, GAP_CYCLES)+1). It resets to 0 at every state transition.
- active: equals the granted event in PLAY/GAP and 0 in IDLE.
- busy: equals (state != IDLE).

Test Plan:
- NOTE_CYCLES=4, GAP_CYCLES=2 for all scenarios.
- Single tick: req_tick at cycle 0.
  - Required: note_code 1 in cycles 1-4, 0 in cycles 5-6, busy low from cycle 7, active 1 during cycles 1-6.
- Simultaneous req_tick+req_goal at cycle 0.
  - Required: goal notes 3, 5, 8 in cycles 1-4, 7-10, 13-16; tick note 1 in cycles 19-22; busy low from cycle 25.
- Preemption: req_goal at 0, req_finish at 6.
  - Required: note 5 visible in cycle 7 is replaced by note 8 (finish) from cycle 7.
  - Finish notes 8, 6, 4, 1 complete; goal does not resume; busy low after the last gap.
- Coalescing: req_goal at 0, req_tick at 2 and 5.
  - Required: tick_drop pulses in cycle 6; exactly one tick melody plays after goal.
- Mute and reset: mute high during the goal melody.
  - Required: note_code 0 and note_valid 0, but busy, active and timing are unchanged.
  - rst at cycle 9: all outputs 0 from cycle 10, p_tick and p_goal cleared.
